mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_DATA_STREAK, default 4, max consecutive data grants while ifetch waits (range 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, m_ready_i wait limit in cycles; 0 disables the timeout (range 0..255).
REQ-003 SHALL use one clock and an asynchronous active-low reset: clk_i  in  1  rising-edge clock; rst_n_i  in  1  asynchronous active-low reset.
REQ-004 d_valid_i  in  1  data-port request; d_we_i  in  1  store when 1; d_addr_i  in  32  byte address; d_wdata_i  in  32  store data; d_wstrb_i  in  4  byte strobes.
REQ-005 d_rdata_o  out  32  load data; d_ready_o  out  1  data transaction complete (one-cycle pulse).
REQ-006 i_valid_i  in  1  ifetch request; i_addr_i  in  32  fetch address; i_rdata_o  out  32  instruction word; i_ready_o  out  1  ifetch complete (one-cycle pulse).
REQ-007 m_valid_o  out  1; m_we_o  out  1; m_addr_o  out  32; m_wdata_o  out  32; m_wstrb_o  out  4; m_rdata_i  in  32; m_ready_i  in  1. These form the shared memory bus.
REQ-008 err_o  out  1  one-cycle pulse on timeout abort, aligned with the aborted requester's ready pulse.

Function
REQ-009 SHALL implement FSM states IDLE, REQ, RESP; the reset state is IDLE.
REQ-010 IDLE, no valid requester: remain in IDLE, all m_* outputs 0.
REQ-011 IDLE, any valid requester: grant per REQ-012, latch that requester's addr/we/wdata/wstrb into internal registers, go to REQ next cycle.
REQ-012 Priority: data wins when both are valid, unless the streak counter equals MAX_DATA_STREAK and i_valid_i=1, in which case ifetch wins.
REQ-013 Streak counter (4 bits): +1 on each data grant made while i_valid_i=1, saturating at MAX_DATA_STREAK; cleared on every ifetch grant; unchanged on a data grant made while i_valid_i=0.
REQ-014 REQ: m_valid_o=1 with the latched fields; ifetch grant drives m_we_o=0, m_wstrb_o=0, m_wdata_o=0. Fields stay stable until m_ready_i.
REQ-015 REQ with m_ready_i=1: capture m_rdata_i into the owner's rdata register, go to RESP; m_valid_o deasserts the next cycle.
REQ-016 RESP: pulse the owner's ready_o for exactly one cycle, rdata_o valid in that cycle; the non-owner's ready_o stays 0; go to IDLE.
REQ-017 d_rdata_o and i_rdata_o SHALL hold their last captured value between transactions; store completions leave d_rdata_o unchanged.
REQ-018 Requesters SHALL hold valid until ready. A valid that drops after the grant does not cancel the transaction; the ready pulse is still issued.
REQ-019 Minimum occupancy is 3 cycles per transaction (IDLE→REQ→RESP); arbitration resumes in the IDLE cycle after RESP.
REQ-020 Timeout: a cycle counter clears on entry to REQ. If it reaches TIMEOUT_CYCLES with no m_ready_i (TIMEOUT_CYCLES≠0): drop m_valid_o, go to RESP, set the owner's rdata to 0, pulse err_o.
REQ-021 If m_ready_i and the timeout occur in the same cycle, m_ready_i wins: normal completion, no err_o.
REQ-022 m_ready_i while not in REQ SHALL be ignored.

Reset
REQ-023 rst_n_i low SHALL asynchronously force IDLE, streak counter 0, timeout counter 0, latched fields 0, rdata registers 0, and all outputs 0.
REQ-024 Reset mid-transaction SHALL abort with no ready or err pulse after release; the first post-reset grant follows REQ-012 with streak 0.

Structure
REQ-025 The state enum arb_state_e (IDLE, REQ, RESP) and owner enum arb_owner_e (OWN_D, OWN_I) SHALL live in butterfly_pkg.
REQ-026 The block SHALL be a single module with no sub-modules; counters and FSM are inline.

Verification
REQ-027 Single ifetch, i_addr_i=0x100, m_ready_i one cycle after m_valid_o, m_rdata_i=0x00000013 → m_addr_o=0x100, m_we_o=0, i_ready_o pulse with i_rdata_o=0x00000013, total 3 cycles from request.
REQ-028 Simultaneous d store (addr 0x2000, wdata 0xDEADBEEF, wstrb 0xF) and ifetch → data granted first (m_we_o=1), ifetch granted right after the RESP→IDLE cycle.
REQ-029 Data continuously valid, ifetch continuously valid, default MAX_DATA_STREAK=4 → grant order D,D,D,D,I,D,D,D,D,I.
REQ-030 TIMEOUT_CYCLES=8, m_ready_i held 0 → m_valid_o drops after 8 REQ cycles; d_ready_o and err_o pulse together; d_rdata_o=0.
REQ-031 rst_n_i asserted in REQ with m_valid_o=1 → m_valid_o=0 immediately (asynchronous); after release no ready pulse appears and the next request is granted from IDLE.
REQ-032 m_ready_i=1 in the same cycle the timeout expires → normal completion with captured data, err_o stays 0.

Source files
------------

// File: rtl/butterfly_pkg.sv
// Shared types and widths for the memory arbiter: FSM state, bus owner and latched request payload.
package butterfly_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned STRB_W   = 4;
    localparam int unsigned STREAK_W = 4;
    localparam int unsigned TMO_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_D = 1'b0,
        OWN_I = 1'b1
    } arb_owner_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of data-port, ifetch-port and shared memory bus signals around the arbiter.
interface mem_arbiter_if;
    import butterfly_pkg::*;

    logic              d_valid_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic [STRB_W-1:0] d_wstrb_i;
    logic [DATA_W-1:0] d_rdata_o;
    logic              d_ready_o;

    logic              i_valid_i;
    logic [ADDR_W-1:0] i_addr_i;
    logic [DATA_W-1:0] i_rdata_o;
    logic              i_ready_o;

    logic              m_valid_o;
    logic              m_we_o;
    logic [ADDR_W-1:0] m_addr_o;
    logic [DATA_W-1:0] m_wdata_o;
    logic [STRB_W-1:0] m_wstrb_o;
    logic [DATA_W-1:0] m_rdata_i;
    logic              m_ready_i;

    logic              err_o;

    // Arbiter side
    modport slave (
        input  d_valid_i, d_we_i, d_addr_i, d_wdata_i, d_wstrb_i,
        input  i_valid_i, i_addr_i,
        input  m_rdata_i, m_ready_i,
        output d_rdata_o, d_ready_o, i_rdata_o, i_ready_o,
        output m_valid_o, m_we_o, m_addr_o, m_wdata_o, m_wstrb_o,
        output err_o
    );

    // Requesters and memory side
    modport master (
        output d_valid_i, d_we_i, d_addr_i, d_wdata_i, d_wstrb_i,
        output i_valid_i, i_addr_i,
        output m_rdata_i, m_ready_i,
        input  d_rdata_o, d_ready_o, i_rdata_o, i_ready_o,
        input  m_valid_o, m_we_o, m_addr_o, m_wdata_o, m_wstrb_o,
        input  err_o
    );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (data / ifetch) arbiter onto one memory bus, with anti-starvation streak
// limit for ifetch and a bounded wait on m_ready_i.
module mem_arbiter
    import butterfly_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 255
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    mem_arbiter_if.slave  bus
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam bit                  TMO_EN     = (TIMEOUT_CYCLES != 0);

    arb_state_e          state_q, state_d;
    arb_owner_e          owner_q, owner_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    mem_req_t            req_q, req_d;
    logic                m_valid_q, m_valid_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic                d_ready_q, d_ready_d;
    logic                i_ready_q, i_ready_d;
    logic                err_q, err_d;
    logic                data_wins;
    logic                timed_out;

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            owner_q   <= OWN_D;
            streak_q  <= '0;
            tmo_q     <= '0;
            req_q     <= '0;
            m_valid_q <= 1'b0;
            d_rdata_q <= '0;
            i_rdata_q <= '0;
            d_ready_q <= 1'b0;
            i_ready_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            streak_q  <= streak_d;
            tmo_q     <= tmo_d;
            req_q     <= req_d;
            m_valid_q <= m_valid_d;
            d_rdata_q <= d_rdata_d;
            i_rdata_q <= i_rdata_d;
            d_ready_q <= d_ready_d;
            i_ready_q <= i_ready_d;
            err_q     <= err_d;
        end
    end

    // Next-state, arbitration and completion logic
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        streak_d  = streak_q;
        tmo_d     = tmo_q;
        req_d     = req_q;
        m_valid_d = m_valid_q;
        d_rdata_d = d_rdata_q;
        i_rdata_d = i_rdata_q;
        d_ready_d = 1'b0;
        i_ready_d = 1'b0;
        err_d     = 1'b0;
        timed_out = 1'b0;

        // ifetch overtakes data only once data has won STREAK_MAX times in a row against it
        data_wins = bus.d_valid_i && !(bus.i_valid_i && (streak_q == STREAK_MAX));

        unique case (state_q)
            IDLE: begin
                if (data_wins) begin
                    owner_d   = OWN_D;
                    req_d     = '{we: bus.d_we_i, addr: bus.d_addr_i,
                                  wdata: bus.d_wdata_i, wstrb: bus.d_wstrb_i};
                    if (bus.i_valid_i && (streak_q < STREAK_MAX)) begin
                        streak_d = streak_q + 1'b1;
                    end
                    tmo_d     = '0;
                    m_valid_d = 1'b1;
                    state_d   = REQ;
                end else if (bus.i_valid_i) begin
                    owner_d   = OWN_I;
                    req_d     = '{we: 1'b0, addr: bus.i_addr_i, wdata: '0, wstrb: '0};
                    streak_d  = '0;
                    tmo_d     = '0;
                    m_valid_d = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                timed_out = !bus.m_ready_i && TMO_EN && (tmo_q == TMO_LAST);
                if (bus.m_ready_i || timed_out) begin
                    m_valid_d = 1'b0;
                    req_d     = '0;
                    err_d     = timed_out;
                    state_d   = RESP;
                    if (owner_q == OWN_D) begin
                        d_ready_d = 1'b1;
                        if (timed_out) begin
                            d_rdata_d = '0;
                        end else if (!req_q.we) begin
                            d_rdata_d = bus.m_rdata_i;
                        end
                    end else begin
                        i_ready_d = 1'b1;
                        i_rdata_d = timed_out ? '0 : bus.m_rdata_i;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.m_valid_o = m_valid_q;
    assign bus.m_we_o    = req_q.we;
    assign bus.m_addr_o  = req_q.addr;
    assign bus.m_wdata_o = req_q.wdata;
    assign bus.m_wstrb_o = req_q.wstrb;
    assign bus.d_rdata_o = d_rdata_q;
    assign bus.d_ready_o = d_ready_q;
    assign bus.i_rdata_o = i_rdata_q;
    assign bus.i_ready_o = i_ready_q;
    assign bus.err_o     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: queue-driven requesters, a latency-programmable memory, a
// transaction-level reference model compared every cycle, and directed literal checks.
module tb_mem_arbiter;
    import butterfly_pkg::*;

    localparam int unsigned MAXS   = 4;
    localparam int unsigned TMO    = 8;
    localparam logic [31:0] RD_KEY = 32'h0000_0113;

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    mem_arbiter_if bus_if ();

    mem_arbiter #(.MAX_DATA_STREAK(MAXS), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus_if.slave)
    );

    always #5 clk_i = ~clk_i;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%s required=%s", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Requesters: each pops its queue and holds valid until its ready pulse
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } dtxn_t;

    dtxn_t       dq[$];
    logic [31:0] iq[$];
    dtxn_t       dcur;
    bit          d_busy = 1'b0;
    bit          i_busy = 1'b0;

    always @(negedge clk_i) begin
        if (bus_if.d_ready_o) d_busy = 1'b0;
        if (!d_busy && dq.size() != 0) begin
            dcur = dq.pop_front();
            bus_if.d_we_i    = dcur.we;
            bus_if.d_addr_i  = dcur.addr;
            bus_if.d_wdata_i = dcur.wdata;
            bus_if.d_wstrb_i = dcur.wstrb;
            d_busy = 1'b1;
        end
        bus_if.d_valid_i = d_busy;
        if (bus_if.i_ready_o) i_busy = 1'b0;
        if (!i_busy && iq.size() != 0) begin
            bus_if.i_addr_i = iq.pop_front();
            i_busy = 1'b1;
        end
        bus_if.i_valid_i = i_busy;
    end

    // Memory: ready after mem_lat bus cycles, data = addr ^ RD_KEY; optional idle-time ready noise
    int unsigned mem_lat  = 0;
    bit          mem_hang = 1'b0;
    bit          spurious = 1'b0;
    int unsigned bus_cnt  = 0;
    int unsigned last_run = 0;

    always @(negedge clk_i) begin
        if (bus_if.m_valid_o) begin
            bus_cnt++;
            bus_if.m_ready_i = !mem_hang && (bus_cnt > mem_lat);
            bus_if.m_rdata_i = bus_if.m_ready_i ? (bus_if.m_addr_o ^ RD_KEY) : 32'hBAD0_0BAD;
        end else begin
            if (bus_cnt != 0) last_run = bus_cnt;
            bus_cnt = 0;
            bus_if.m_ready_i = spurious;
            bus_if.m_rdata_i = 32'hFFFF_FFFF;
        end
    end

    // Reference model: phase 0 = bus free, 1 = transfer in flight, 2 = reply cycle
    int          m_phase  = 0;
    int          m_streak = 0;
    int          m_waited = 0;
    bit          m_own_i  = 1'b0;
    bit          take_d, done, timed_out, was_store;
    logic        e_mvalid, e_mwe, e_dready, e_iready, e_err;
    logic [31:0] e_maddr, e_mwdata, e_drdata, e_irdata;
    logic [3:0]  e_mwstrb;
    string       model_log = "";
    string       dut_log   = "";

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            m_phase = 0; m_streak = 0; m_waited = 0; m_own_i = 1'b0;
            e_mvalid = 0; e_mwe = 0; e_maddr = 0; e_mwdata = 0; e_mwstrb = 0;
            e_dready = 0; e_iready = 0; e_err = 0; e_drdata = 0; e_irdata = 0;
        end else begin
            e_dready = 0; e_iready = 0; e_err = 0;
            if (m_phase == 0) begin
                take_d = bus_if.d_valid_i && !(bus_if.i_valid_i && m_streak >= int'(MAXS));
                if (take_d) begin
                    m_own_i = 1'b0;
                    e_mwe = bus_if.d_we_i; e_maddr = bus_if.d_addr_i;
                    e_mwdata = bus_if.d_wdata_i; e_mwstrb = bus_if.d_wstrb_i;
                    if (bus_if.i_valid_i) m_streak = (m_streak + 1 > int'(MAXS)) ? int'(MAXS) : m_streak + 1;
                    model_log = {model_log, "D"};
                end else if (bus_if.i_valid_i) begin
                    m_own_i = 1'b1;
                    e_mwe = 0; e_maddr = bus_if.i_addr_i; e_mwdata = 0; e_mwstrb = 0;
                    m_streak = 0;
                    model_log = {model_log, "I"};
                end
                if (take_d || bus_if.i_valid_i) begin
                    m_phase = 1; m_waited = 0; e_mvalid = 1;
                end
            end else if (m_phase == 1) begin
                done = (bus_if.m_ready_i === 1'b1);
                timed_out = 1'b0;
                if (!done) begin
                    m_waited++;
                    timed_out = (TMO != 0) && (m_waited >= int'(TMO));
                end
                if (done || timed_out) begin
                    was_store = e_mwe;
                    m_phase = 2;
                    e_mvalid = 0; e_mwe = 0; e_maddr = 0; e_mwdata = 0; e_mwstrb = 0;
                    e_err = timed_out;
                    if (m_own_i) begin
                        e_iready = 1;
                        e_irdata = timed_out ? 32'h0 : bus_if.m_rdata_i;
                    end else begin
                        e_dready = 1;
                        if (timed_out) e_drdata = 0;
                        else if (!was_store) e_drdata = bus_if.m_rdata_i;
                    end
                end
            end else begin
                m_phase = 0;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clk_i) begin
        check32("m_valid_o", bus_if.m_valid_o, e_mvalid);
        check32("m_we_o",    bus_if.m_we_o,    e_mwe);
        check32("m_addr_o",  bus_if.m_addr_o,  e_maddr);
        check32("m_wdata_o", bus_if.m_wdata_o, e_mwdata);
        check32("m_wstrb_o", bus_if.m_wstrb_o, e_mwstrb);
        check32("d_ready_o", bus_if.d_ready_o, e_dready);
        check32("i_ready_o", bus_if.i_ready_o, e_iready);
        check32("d_rdata_o", bus_if.d_rdata_o, e_drdata);
        check32("i_rdata_o", bus_if.i_rdata_o, e_irdata);
        check32("err_o",     bus_if.err_o,     e_err);
        if (bus_if.d_ready_o) dut_log = {dut_log, "D"};
        if (bus_if.i_ready_o) dut_log = {dut_log, "I"};
    end

    // Grant capture: records the fields and cycle index of each m_valid_o rising edge
    logic        g_we[4];
    logic [31:0] g_addr[4], g_wdata[4];
    logic [3:0]  g_wstrb[4];
    int          g_cyc[4];
    int          g_n;

    task automatic capture_grants(input int n_ticks);
        logic prev;
        prev = 1'b0;
        g_n  = 0;
        for (int k = 0; k < 4; k++) begin
            g_we[k] = 0; g_addr[k] = 0; g_wdata[k] = 0; g_wstrb[k] = 0; g_cyc[k] = 0;
        end
        for (int c = 1; c <= n_ticks; c++) begin
            tick();
            if (bus_if.m_valid_o && !prev && g_n < 4) begin
                g_we[g_n] = bus_if.m_we_o; g_addr[g_n] = bus_if.m_addr_o;
                g_wdata[g_n] = bus_if.m_wdata_o; g_wstrb[g_n] = bus_if.m_wstrb_o;
                g_cyc[g_n] = c;
                g_n++;
            end
            prev = bus_if.m_valid_o;
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while ((d_busy || i_busy || dq.size() != 0 || iq.size() != 0 ||
                bus_if.m_valid_o || m_phase != 0) && n < budget) begin
            tick();
            n++;
        end
        tick();
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s drain actual=%0d cycles required<%0d", name, n, budget);
        end
    endtask

    task automatic flush_requesters();
        dq.delete(); iq.delete();
        d_busy = 1'b0; i_busy = 1'b0;
        bus_if.d_valid_i = 1'b0; bus_if.i_valid_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        bus_if.d_valid_i = 0; bus_if.d_we_i = 0; bus_if.d_addr_i = 0;
        bus_if.d_wdata_i = 0; bus_if.d_wstrb_i = 0;
        bus_if.i_valid_i = 0; bus_if.i_addr_i = 0;
        bus_if.m_rdata_i = 0; bus_if.m_ready_i = 0;

        repeat (3) @(posedge clk_i);
        #1;
        check32("rst_m_valid", bus_if.m_valid_o, 32'h0);
        check32("rst_d_rdata", bus_if.d_rdata_o, 32'h0);
        check32("rst_err",     bus_if.err_o,     32'h0);
        rst_n_i = 1'b1;
        tick();

        // Single ifetch: IDLE -> REQ -> RESP
        iq.push_back(32'h100);
        tick();
        check32("if_m_valid", bus_if.m_valid_o, 32'h1);
        check32("if_m_addr",  bus_if.m_addr_o,  32'h100);
        check32("if_m_we",    bus_if.m_we_o,    32'h0);
        tick();
        check32("if_ready",   bus_if.i_ready_o, 32'h1);
        check32("if_rdata",   bus_if.i_rdata_o, 32'h13);
        tick();
        check32("if_ready_end", bus_if.i_ready_o, 32'h0);
        check32("if_idle",      bus_if.m_valid_o, 32'h0);
        wait_done("ifetch", 20);

        // Simultaneous store and ifetch, with m_ready_i noise outside transfers
        spurious = 1'b1;
        dq.push_back('{1'b1, 32'h2000, 32'hDEADBEEF, 4'hF});
        iq.push_back(32'h300);
        capture_grants(12);
        spurious = 1'b0;
        check32("sim_first_we",    g_we[0],    32'h1);
        check32("sim_first_addr",  g_addr[0],  32'h2000);
        check32("sim_first_wdata", g_wdata[0], 32'hDEADBEEF);
        check32("sim_first_wstrb", g_wstrb[0], 32'hF);
        check32("sim_second_we",   g_we[1],    32'h0);
        check32("sim_second_addr", g_addr[1],  32'h300);
        check32("sim_grant_gap",   32'(g_cyc[1] - g_cyc[0]), 32'd3);
        check32("sim_d_rdata_kept", bus_if.d_rdata_o, 32'h0);
        wait_done("simultaneous", 30);

        // Load to give d_rdata_o a non-zero value
        dq.push_back('{1'b0, 32'h40, 32'h0, 4'h0});
        wait_done("load40", 20);
        check32("load40_rdata", bus_if.d_rdata_o, 32'h153);

        // Timeout with m_ready_i held low
        mem_hang = 1'b1;
        dq.push_back('{1'b0, 32'h44, 32'h0, 4'h0});
        seen = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            tick();
            if (bus_if.d_ready_o) seen = 1'b1;
        end
        check32("to_seen",   32'(seen),         32'h1);
        check32("to_err",    bus_if.err_o,      32'h1);
        check32("to_drdata", bus_if.d_rdata_o,  32'h0);
        tick();
        check32("to_err_pulse", bus_if.err_o, 32'h0);
        check32("to_run",       last_run,     32'd8);
        mem_hang = 1'b0;
        wait_done("timeout", 20);

        // m_ready_i in the cycle the timeout would fire
        mem_lat = 7;
        dq.push_back('{1'b0, 32'h80, 32'h0, 4'h0});
        seen = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            tick();
            if (bus_if.d_ready_o) seen = 1'b1;
        end
        check32("race_seen",   32'(seen),        32'h1);
        check32("race_err",    bus_if.err_o,     32'h0);
        check32("race_drdata", bus_if.d_rdata_o, 32'h193);
        tick();
        check32("race_run",    last_run,         32'd8);
        mem_lat = 0;
        wait_done("race", 20);

        // Reset while a transfer is on the bus
        mem_hang = 1'b1;
        dq.push_back('{1'b0, 32'h500, 32'h0, 4'h0});
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            tick();
            if (bus_if.m_valid_o) seen = 1'b1;
        end
        check32("rst_mid_valid_before", 32'(seen), 32'h1);
        #1 rst_n_i = 1'b0;
        #1;
        check32("rst_mid_valid_async", bus_if.m_valid_o, 32'h0);
        flush_requesters();
        mem_hang = 1'b0;
        tick();
        @(negedge clk_i);
        #2 rst_n_i = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
            check32("post_rst_quiet",
                    {28'h0, bus_if.d_ready_o, bus_if.i_ready_o, bus_if.err_o, bus_if.m_valid_o},
                    32'h0);
        end
        dq.push_back('{1'b0, 32'h600, 32'h0, 4'h0});
        iq.push_back(32'h700);
        capture_grants(12);
        check32("post_rst_first_addr",  g_addr[0], 32'h600);
        check32("post_rst_first_cyc",   g_cyc[0],  32'd1);
        check32("post_rst_second_addr", g_addr[1], 32'h700);
        wait_done("post_reset", 30);

        // Both requesters continuously valid: streak limit forces every fifth grant to ifetch
        mem_lat   = 1;
        dut_log   = "";
        model_log = "";
        for (int k = 0; k < 8; k++) begin
            dq.push_back('{1'(k % 2), 32'h1000 + 32'(4 * k), 32'h1111_1111 * 32'(k), 4'hF});
        end
        iq.push_back(32'h800);
        iq.push_back(32'h804);
        wait_done("streak", 200);
        check_str("streak_dut_order",   dut_log,   "DDDDIDDDDI");
        check_str("streak_model_order", model_log, "DDDDIDDDDI");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
